// File: rtl/fp_to_int_sched.sv
// Round-robin scheduler in front of one float-to-int conversion datapath.
// Each accepted operand goes through IDLE -> CLASSIFY -> SHIFT -> RESP.
// The result is held in RESP until the consumer takes it, so a new operand
// is accepted at most once every four cycles.
module fp_to_int_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [4:0]           rsp_flags
);

    typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, RESP} state_t;

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      ptr_next;
    logic                grant_found;
    logic [31:0]         op_sel;

    // Captured operand and owner
    logic [31:0]         op_reg;
    logic [IDW-1:0]      id_reg;

    // Classification results
    logic                sign_reg;
    logic signed [9:0]   e_reg;
    logic [23:0]         sig_reg;
    logic                nan_reg;
    logic                inf_reg;
    logic                zero_reg;
    logic                denorm_reg;

    // Shift-stage results
    logic [31:0]         mag;
    logic [31:0]         shift_data;
    logic                shift_ovf;

    // Round-robin search starting at ptr, wrapping past NREQ-1
    always_comb begin
        int            cand;
        logic [IDW-1:0] cidx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cidx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cidx = IDW'(cand);
            if (!grant_found && req_valid[cidx]) begin
                grant_found = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    // Pointer advances to the requester after the one granted
    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Operand of the granted requester
    always_comb begin
        op_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                op_sel = req_data[k*32 +: 32];
            end
        end
    end

    // Grant is shown combinationally only while idle and out of reset
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state == IDLE) && grant_found &&
                                   (grant_idx == IDW'(gi));
        end
    endgenerate

    // Saturating truncation of the classified operand to a signed 32-bit value
    always_comb begin
        mag        = '0;
        shift_data = '0;
        shift_ovf  = 1'b0;
        if (nan_reg || inf_reg || (e_reg > 10'sd31)) begin
            shift_data = 32'h8000_0000;
            shift_ovf  = 1'b1;
        end else if (e_reg < 10'sd0) begin
            shift_data = '0;
        end else if (e_reg == 10'sd31) begin
            // Only -2^31 is representable at this exponent
            shift_data = 32'h8000_0000;
            shift_ovf  = !(sign_reg && (sig_reg[22:0] == 23'd0));
        end else begin
            if (e_reg >= 10'sd23) begin
                mag = {8'd0, sig_reg} << (e_reg[4:0] - 5'd23);
            end else begin
                mag = {8'd0, sig_reg} >> (5'd23 - e_reg[4:0]);
            end
            shift_data = sign_reg ? (~mag + 32'd1) : mag;
        end
    end

    // Scheduler FSM with the conversion pipeline and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            op_reg     <= '0;
            id_reg     <= '0;
            sign_reg   <= 1'b0;
            e_reg      <= '0;
            sig_reg    <= '0;
            nan_reg    <= 1'b0;
            inf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_reg <= op_sel;
                        id_reg <= grant_idx;
                        ptr    <= ptr_next;
                        state  <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    sign_reg   <= op_reg[31];
                    e_reg      <= $signed({2'b00, op_reg[30:23]}) - 10'sd127;
                    sig_reg    <= {1'b1, op_reg[22:0]};
                    nan_reg    <= (op_reg[30:23] == 8'hFF) && (op_reg[22:0] != 23'd0);
                    inf_reg    <= (op_reg[30:23] == 8'hFF) && (op_reg[22:0] == 23'd0);
                    zero_reg   <= (op_reg[30:23] == 8'h00) && (op_reg[22:0] == 23'd0);
                    denorm_reg <= (op_reg[30:23] == 8'h00) && (op_reg[22:0] != 23'd0);
                    state      <= SHIFT;
                end
                SHIFT: begin
                    rsp_data  <= shift_data;
                    rsp_id    <= id_reg;
                    rsp_flags <= {nan_reg, inf_reg, zero_reg, denorm_reg, shift_ovf};
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_sched.sv
// Bench for fp_to_int_sched: a cycle-level reference model of arbitration and
// conversion, checked on every falling edge, plus directed operand vectors.
module tb_fp_to_int_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic [4:0]           rsp_flags;

    fp_to_int_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_flags (rsp_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: exact real value, truncated toward zero, then
    // checked against the signed 32-bit range.
    function automatic void model_conv(input logic [31:0] op, output logic [31:0] d,
                                       output logic [4:0] f);
        logic [7:0]  ex;
        logic [22:0] fr;
        logic        nan, inf, zero, den, ovf;
        real         v, fl;
        longint      m, s;
        ex   = op[30:23];
        fr   = op[22:0];
        nan  = (ex == 8'hFF) && (fr != 0);
        inf  = (ex == 8'hFF) && (fr == 0);
        zero = (ex == 8'h00) && (fr == 0);
        den  = (ex == 8'h00) && (fr != 0);
        ovf  = 1'b0;
        d    = 32'd0;
        if (ex == 8'hFF) begin
            d   = 32'h8000_0000;
            ovf = 1'b1;
        end else begin
            if (ex == 8'h00) v = 0.0;
            else v = real'({1'b1, fr}) * (2.0 ** real'(int'(ex) - 150));
            fl = $floor(v);
            if (fl > 2147483648.0 || (fl == 2147483648.0 && !op[31])) begin
                d   = 32'h8000_0000;
                ovf = 1'b1;
            end else begin
                m = longint'(fl);
                s = op[31] ? -m : m;
                d = s[31:0];
            end
        end
        f = {nan, inf, zero, den, ovf};
    endfunction

    // Model state, written only by the compare process
    logic          m_busy = 1'b0;
    int            m_ptr  = 0;
    int            m_cnt  = 0;
    logic [31:0]   e_d;
    logic [4:0]    e_f;
    int            e_id;
    int            grant_log[$];
    int            hs_count = 0;
    logic [31:0]   last_d;
    logic [4:0]    last_f;
    int            last_id;
    int            last_lat;

    // Compare process: DUT against model on every falling edge
    always @(negedge clk) begin
        int  c;
        int  g;
        logic found;
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_flags", rsp_flags, 0);
            chk("rst_req_ready", req_ready, 0);
            m_busy = 1'b0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            chk("grant", req_ready, found ? (64'd1 << g) : 64'd0);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (found) begin
                model_conv(req_data[g*32 +: 32], e_d, e_f);
                e_id   = g;
                m_ptr  = (g + 1) % NREQ;
                m_busy = 1'b1;
                m_cnt  = 0;
                grant_log.push_back(g);
            end
        end else begin
            m_cnt++;
            chk("busy_req_ready", req_ready, 0);
            if (m_cnt < 3) begin
                chk("early_rsp_valid", rsp_valid, 0);
            end else begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_data", rsp_data, e_d);
                chk("rsp_id", rsp_id, e_id);
                chk("rsp_flags", rsp_flags, e_f);
                if (rsp_ready) begin
                    $display("rsp id=%0d data=0x%08h flags=%05b latency=%0d",
                             rsp_id, rsp_data, rsp_flags, m_cnt);
                    last_d   = rsp_data;
                    last_f   = rsp_flags;
                    last_id  = int'(rsp_id);
                    last_lat = m_cnt;
                    m_busy   = 1'b0;
                    hs_count++;
                end
            end
        end
    end

    // Directed operands with hand-computed results; flags = {nan,inf,zero,denorm,ovf}
    localparam logic [31:0] V_OP [16] = '{
        32'h4040_0000, 32'hC030_0000, 32'h3F00_0000, 32'h0000_0001,
        32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
        32'h0000_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F80_0000,
        32'hBF80_0000, 32'h4B00_0001, 32'hCF00_0001, 32'h4F80_0000};
    localparam logic [31:0] V_D [16] = '{
        32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000,
        32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
        32'h0000_0000, 32'h7FFF_FF80, 32'h8000_0080, 32'h0000_0001,
        32'hFFFF_FFFF, 32'h0080_0001, 32'h8000_0000, 32'h8000_0000};
    localparam logic [4:0] V_F [16] = '{
        5'b00000, 5'b00000, 5'b00000, 5'b00010,
        5'b00001, 5'b00000, 5'b10001, 5'b01001,
        5'b00100, 5'b00000, 5'b00000, 5'b00000,
        5'b00000, 5'b00000, 5'b00001, 5'b00001};

    // Present one operand, retire it, and wait for its response
    task automatic send(input int i, input logic [31:0] op);
        logic got;
        int   start;
        @(posedge clk); #1;
        req_valid[i]        = 1'b1;
        req_data[i*32 +: 32] = op;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk("grant_wait", got, 1);
        start = hs_count;
        @(posedge clk); #1;
        req_valid[i]        = 1'b0;
        req_data[i*32 +: 32] = ~op;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (hs_count != start) got = 1'b1;
        end
        chk("rsp_wait", got, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (!m_busy) ok = 1'b1;
        end
        chk("idle_wait", ok, 1);
    endtask

    initial begin
        logic [31:0] md;
        logic [4:0]  mf;
        logic        ok;
        int          start;

        // All requesters valid straight out of reset: grants 0,1,2,3,0
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(posedge clk); #1;
            if (grant_log.size() >= 5) ok = 1'b1;
        end
        chk("rr_wait", ok, 1);
        req_valid = '0;
        if (ok) begin
            chk("rr_grant0", grant_log[0], 0);
            chk("rr_grant1", grant_log[1], 1);
            chk("rr_grant2", grant_log[2], 2);
            chk("rr_grant3", grant_log[3], 3);
            chk("rr_grant4", grant_log[4], 0);
        end
        wait_idle();

        // Directed conversions, rotating through requesters starting at 1
        for (int i = 0; i < 16; i++) begin
            model_conv(V_OP[i], md, mf);
            chk("model_data", md, V_D[i]);
            chk("model_flags", mf, V_F[i]);
            send((i + 1) % NREQ, V_OP[i]);
            chk("vec_data", last_d, V_D[i]);
            chk("vec_flags", last_f, V_F[i]);
            chk("vec_id", last_id, (i + 1) % NREQ);
            if (i == 0) chk("latency", last_lat, 3);
        end

        // Consumer stalls five cycles in RESP with another request pending
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_data[2*32 +: 32] = 32'h4120_0000;
        req_data[3*32 +: 32] = 32'hC120_0000;
        req_valid = 4'b1100;
        start = hs_count;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        chk("stall_rsp_wait", ok, 1);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(posedge clk); #1;
            if (hs_count - start >= 2) ok = 1'b1;
        end
        chk("stall_pair_wait", ok, 1);
        req_valid = '0;
        chk("stall_last_id", last_id, 3);
        chk("stall_last_data", last_d, 32'hFFFF_FFF6);
        wait_idle();

        // Reset during SHIFT aborts the conversion and rewinds the pointer
        req_valid[1]     = 1'b1;
        req_data[1*32 +: 32] = 32'h4100_0000;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[1]) ok = 1'b1;
        end
        chk("abort_grant_wait", ok, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_data[0*32 +: 32] = 32'h40A0_0000;
        req_data[2*32 +: 32] = 32'h40C0_0000;
        req_valid = 4'b0101;
        grant_log.delete();
        start = hs_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (grant_log.size() > 0) ok = 1'b1;
        end
        chk("post_reset_grant_wait", ok, 1);
        if (ok) chk("post_reset_grant", grant_log[0], 0);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (hs_count != start) ok = 1'b1;
        end
        req_valid = '0;
        chk("post_reset_rsp_wait", ok, 1);
        chk("post_reset_data", last_d, 5);
        chk("post_reset_id", last_id, 0);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/fp_to_int_sched.md
FP_TO_INT_SCHED -- requirements
Module: fp_to_int_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one float-to-int conversion datapath (2..8).
REQ-002 SHALL have parameter IDW, default $clog2(NREQ), width of the requester ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  bit i: requester i presents an operand.
REQ-006 req_data  input  32*NREQ  slice [32i+31:32i]: IEEE-754 single-precision operand {sign, exp[7:0], frac[22:0]} of requester i.
REQ-007 req_ready  output  NREQ  bit i: operand of requester i accepted this cycle; at most one bit high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_data  output  32  signed 32-bit integer result.
REQ-011 rsp_id  output  IDW  index of the requester that owns rsp_data.
REQ-012 rsp_flags  output  5  {nan, inf, zero, denorm, ovf} classification of the operand.

Function
REQ-013 SHALL implement FSM states IDLE, CLASSIFY, SHIFT, RESP.
REQ-014 IDLE: if any req_valid high, SHALL grant one requester by round-robin, drive req_ready[grant] high combinationally that cycle, capture its operand and ID, and go to CLASSIFY; else remain IDLE with req_ready all zero.
REQ-015 Round-robin: search starts at index ptr, wrapping NREQ-1 to 0; on grant g, ptr SHALL become (g+1) mod NREQ; ptr unchanged when there is no grant.
REQ-016 req_ready SHALL be all zero in CLASSIFY, SHIFT, RESP.
REQ-017 CLASSIFY (1 cycle): SHALL register flags and unbiased exponent e = exp-127 and significand {1, frac}; go to SHIFT.
REQ-018 SHIFT (1 cycle): SHALL register rsp_data per REQ-020..REQ-024; go to RESP.
REQ-019 RESP: rsp_valid high, rsp_data/rsp_id/rsp_flags stable; on rsp_valid and rsp_ready SHALL go to IDLE; no new request is accepted in the same cycle. Accept at cycle T gives rsp_valid at T+3; minimum issue interval is 4 cycles.
REQ-020 nan = (exp==255 and frac!=0); inf = (exp==255 and frac==0); zero = (exp==0 and frac==0); denorm = (exp==0 and frac!=0).
REQ-021 nan, inf, or exp>158: rsp_data SHALL be 0x80000000 with ovf=1.
REQ-022 exp<127 (includes zero and denorm): rsp_data SHALL be 0, ovf=0.
REQ-023 127<=exp<=158: magnitude = significand shifted left by e-23 when e>=23, else right by 23-e (truncation toward zero); result = sign ? -magnitude : magnitude, computed in 32-bit two's complement.
REQ-024 exp==158: sign=1 and frac==0 SHALL give 0x80000000 with ovf=0; any other exp==158 operand SHALL give 0x80000000 with ovf=1.
REQ-025 Only the granted requester's operand is captured; operands of other requesters are ignored until granted; req_data changes after acceptance SHALL NOT affect the result.

Reset
REQ-026 While rst_n low, SHALL force: state IDLE, ptr 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_flags 0, req_ready all 0.
REQ-027 Assertion of rst_n in any state SHALL abort the in-flight conversion with no response issued; after release the first grant search starts at index 0.

Verification
REQ-028 Requester 1 sends 0x40400000 (3.0) at cycle T -> rsp_valid at T+3, rsp_data 3, rsp_id 1, rsp_flags 0.
REQ-029 0xC0300000 (-2.75) -> rsp_data 0xFFFFFFFE (-2); 0x3F000000 (0.5) -> 0; 0x00000001 -> 0 with denorm=1.
REQ-030 All four req_valid held high from reset -> grants in order 0,1,2,3,0; each req_ready pulses exactly one cycle.
REQ-031 0x4F000000 -> 0x80000000 ovf=1; 0xCF000000 -> 0x80000000 ovf=0; 0x7FC00000 -> 0x80000000 nan=1 ovf=1; 0xFF800000 -> 0x80000000 inf=1 ovf=1.
REQ-032 rsp_ready low for 5 cycles in RESP -> rsp_valid and outputs held stable, req_ready stays zero; on the cycle after rsp_ready rises, a pending request is granted.
REQ-033 rst_n pulsed low during SHIFT -> no rsp_valid for that operand; outputs zero; next request from requester 2 with requester 0 also valid -> requester 0 granted first.
